// File: rtl/vx_tlb_ptw_pkg.sv
// Shared constants and types for the TLB miss-side page-table walker.
package vx_tlb_ptw_pkg;

  localparam int XLEN          = 32;
  localparam int PERF_CTR_BITS = 32;

  localparam int PTE_V       = 0;
  localparam int PTE_R       = 1;
  localparam int PTE_W       = 2;
  localparam int PTE_X       = 3;
  localparam int PTE_PPN_LSB = 10;

  typedef enum logic [1:0] {
    PTW_IDLE,
    PTW_MEM_REQ,
    PTW_MEM_RSP,
    PTW_RESP
  } ptw_state_e;

  typedef struct packed {
    logic [PERF_CTR_BITS-1:0] walks;
    logic [PERF_CTR_BITS-1:0] faults;
  } ptw_perf_t;

  // Any of R/W/X set marks a leaf PTE.
  function automatic logic pte_is_leaf(input logic [2:0] rwx);
    return |rwx;
  endfunction

endpackage

// File: rtl/vx_tlb_ptw_arb.sv
// Round-robin arbiter: lowest index at or after the pointer wins; pointer moves past the winner on accept.
module vx_tlb_ptw_arb #(
  parameter int NUM_REQS = 4,
  localparam int IDX_W   = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] req,
  input  logic                accept,
  output logic [NUM_REQS-1:0] grant,
  output logic [IDX_W-1:0]    grant_idx
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    found     = 1'b0;
    cand      = '0;
    grant_idx = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      cand = IDX_W'((int'(ptr_q) + i) % NUM_REQS);
      if (!found && req[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    grant = found ? (NUM_REQS'(1) << grant_idx) : '0;
    ptr_d = ptr_q;
    if (accept && found) begin
      ptr_d = IDX_W'((int'(grant_idx) + 1) % NUM_REQS);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/vx_tlb_ptw.sv
// Page-table walker: arbitrates per-bank TLB misses and runs one radix walk at a time over a single PTE read port.
//
// state       | meaning
// PTW_IDLE    | granting a bank miss (round-robin)
// PTW_MEM_REQ | PTE read request presented, address held
// PTW_MEM_RSP | waiting for PTE data, then decode
// PTW_RESP    | result held on the originating bank until accepted
module vx_tlb_ptw
  import vx_tlb_ptw_pkg::*;
#(
  parameter int NUM_BANKS         = 4,
  parameter int LEVELS            = 2,
  parameter int VPN_IDX_BITS      = 10,
  parameter int PTE_BYTES         = 4,
  parameter int PAGE_OFFSET_WIDTH = 12,
  parameter int VPN_WIDTH         = XLEN - PAGE_OFFSET_WIDTH,
  parameter int PPN_WIDTH         = XLEN - PAGE_OFFSET_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [PPN_WIDTH-1:0]                 satp_ppn,
  input  logic [NUM_BANKS-1:0]                 tlb_miss_valid_i,
  input  logic [NUM_BANKS-1:0][VPN_WIDTH-1:0]  tlb_miss_vpn_i,
  output logic [NUM_BANKS-1:0]                 tlb_miss_ready_o,
  output logic [NUM_BANKS-1:0]                 tlb_update_valid_o,
  output logic [NUM_BANKS-1:0][VPN_WIDTH-1:0]  tlb_update_vpn_o,
  output logic [NUM_BANKS-1:0][PPN_WIDTH-1:0]  tlb_update_ppn_o,
  output logic                                 tlb_update_fault_o,
  input  logic [NUM_BANKS-1:0]                 tlb_update_ready_i,
  output logic                                 mem_req_valid,
  output logic [XLEN-1:0]                      mem_req_addr,
  input  logic                                 mem_req_ready,
  input  logic                                 mem_rsp_valid,
  input  logic [8*PTE_BYTES-1:0]               mem_rsp_data,
  output logic                                 mem_rsp_ready,
  output logic [PERF_CTR_BITS-1:0]             perf_walks,
  output logic [PERF_CTR_BITS-1:0]             perf_faults
);

  localparam int PTE_WIDTH = 8 * PTE_BYTES;
  localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int LVL_W     = (LEVELS > 1) ? $clog2(LEVELS) : 1;

  ptw_state_e              state_q, state_d;
  logic [BANK_W-1:0]       bank_q, bank_d;
  logic [VPN_WIDTH-1:0]    vpn_q, vpn_d;
  logic [PPN_WIDTH-1:0]    base_q, base_d;
  logic [LVL_W-1:0]        level_q, level_d;
  logic [PPN_WIDTH-1:0]    ppn_q, ppn_d;
  logic                    fault_q, fault_d;
  ptw_perf_t               perf_q, perf_d;

  logic [NUM_BANKS-1:0]    arb_req;
  logic [NUM_BANKS-1:0]    arb_grant;
  logic [BANK_W-1:0]       grant_idx;
  logic                    miss_fire;
  logic [VPN_IDX_BITS-1:0] cur_idx;
  logic [PPN_WIDTH-1:0]    pte_ppn;
  logic                    pte_valid;
  logic                    pte_leaf;
  logic                    walk_fault;
  logic                    unused_pte_bits;

  assign arb_req = tlb_miss_valid_i & {NUM_BANKS{state_q == PTW_IDLE}};

  vx_tlb_ptw_arb #(
    .NUM_REQS (NUM_BANKS)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (arb_req),
    .accept    (miss_fire),
    .grant     (arb_grant),
    .grant_idx (grant_idx)
  );

  assign tlb_miss_ready_o = arb_grant;
  assign miss_fire        = |(tlb_miss_valid_i & arb_grant);

  assign pte_ppn         = PPN_WIDTH'(mem_rsp_data[PTE_WIDTH-1:PTE_PPN_LSB]);
  assign pte_valid       = mem_rsp_data[PTE_V];
  assign pte_leaf        = pte_is_leaf(mem_rsp_data[PTE_X:PTE_R]);
  assign unused_pte_bits = ^mem_rsp_data[PTE_PPN_LSB-1:PTE_X+1];

  // Superpage leaves and non-leaf entries at the last level are both reported as faults.
  assign walk_fault = !pte_valid || (pte_leaf && (level_q != '0)) || (!pte_leaf && (level_q == '0));

  always_comb begin
    cur_idx = '0;
    for (int l = 0; l < LEVELS; l++) begin
      if (level_q == LVL_W'(l)) begin
        cur_idx = vpn_q[l*VPN_IDX_BITS +: VPN_IDX_BITS];
      end
    end
    mem_req_addr = (XLEN'(base_q) << PAGE_OFFSET_WIDTH) + XLEN'(cur_idx) * XLEN'(PTE_BYTES);
  end

  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    vpn_d   = vpn_q;
    base_d  = base_q;
    level_d = level_q;
    ppn_d   = ppn_q;
    fault_d = fault_q;
    perf_d  = perf_q;
    unique case (state_q)
      PTW_IDLE: begin
        if (miss_fire) begin
          bank_d  = grant_idx;
          vpn_d   = tlb_miss_vpn_i[grant_idx];
          base_d  = satp_ppn;
          level_d = LVL_W'(LEVELS - 1);
          ppn_d   = '0;
          fault_d = 1'b0;
          state_d = PTW_MEM_REQ;
        end
      end
      PTW_MEM_REQ: begin
        if (mem_req_ready) begin
          state_d = PTW_MEM_RSP;
        end
      end
      PTW_MEM_RSP: begin
        if (mem_rsp_valid) begin
          if (walk_fault) begin
            fault_d = 1'b1;
            ppn_d   = '0;
            state_d = PTW_RESP;
          end else if (pte_leaf) begin
            ppn_d   = pte_ppn;
            state_d = PTW_RESP;
          end else begin
            base_d  = pte_ppn;
            level_d = level_q - 1'b1;
            state_d = PTW_MEM_REQ;
          end
        end
      end
      PTW_RESP: begin
        if (tlb_update_ready_i[bank_q]) begin
          perf_d.walks = perf_q.walks + PERF_CTR_BITS'(1);
          if (fault_q) begin
            perf_d.faults = perf_q.faults + PERF_CTR_BITS'(1);
          end
          state_d = PTW_IDLE;
        end
      end
      default: state_d = PTW_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= PTW_IDLE;
      bank_q  <= '0;
      vpn_q   <= '0;
      base_q  <= '0;
      level_q <= '0;
      ppn_q   <= '0;
      fault_q <= 1'b0;
      perf_q  <= '0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      vpn_q   <= vpn_d;
      base_q  <= base_d;
      level_q <= level_d;
      ppn_q   <= ppn_d;
      fault_q <= fault_d;
      perf_q  <= perf_d;
    end
  end

  assign mem_req_valid      = (state_q == PTW_MEM_REQ);
  assign mem_rsp_ready      = (state_q == PTW_MEM_RSP);
  assign tlb_update_valid_o = (state_q == PTW_RESP) ? (NUM_BANKS'(1) << bank_q) : '0;
  assign tlb_update_fault_o = (state_q == PTW_RESP) && fault_q;
  assign tlb_update_vpn_o   = {NUM_BANKS{vpn_q}};
  assign tlb_update_ppn_o   = {NUM_BANKS{ppn_q}};
  assign perf_walks         = perf_q.walks;
  assign perf_faults        = perf_q.faults;

endmodule

// File: doc/vx_tlb_ptw.md
Name: vx_tlb_ptw

Overview:
Page-table walker at the miss side of the banked TLB. It accepts per-bank miss requests (VPN), round-robin arbitrates between banks and performs one multi-level radix walk at a time through a single memory read port. It returns the translated PPN, or a fault, on the originating bank's update interface. Single outstanding walk; banks stall on their miss handshake while the walker is busy.

Parameters:
NUM_BANKS, 4, number of TLB banks (miss/update channel pairs); power of 2
LEVELS, 2, page-table levels; VPN split into LEVELS index fields, most significant first
VPN_IDX_BITS, 10, bits per level index; LEVELS*VPN_IDX_BITS == VPN_WIDTH
PTE_BYTES, 4, PTE size in bytes; PTE_WIDTH = 8*PTE_BYTES
PAGE_OFFSET_WIDTH, 12, page offset bits (4KB pages)
VPN_WIDTH / PPN_WIDTH, `XLEN-PAGE_OFFSET_WIDTH, page number widths

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
satp_ppn  in  PPN_WIDTH  root page-table PPN; sampled at walk acceptance
tlb_miss_valid_i  in  NUM_BANKS  per-bank miss request
tlb_miss_vpn_i  in  NUM_BANKS x VPN_WIDTH  VPN to translate
tlb_miss_ready_o  out  NUM_BANKS  one-hot grant, accepts miss
tlb_update_valid_o  out  NUM_BANKS  one-hot translation result valid
tlb_update_vpn_o  out  NUM_BANKS x VPN_WIDTH  VPN of result (same value on all banks)
tlb_update_ppn_o  out  NUM_BANKS x PPN_WIDTH  translated PPN (0 on fault)
tlb_update_fault_o  out  1  result is a page fault
tlb_update_ready_i  in  NUM_BANKS  bank accepts result
mem_req_valid  out  1  PTE read request
mem_req_addr  out  `XLEN  PTE byte address
mem_req_ready  in  1  memory accepts request
mem_rsp_valid  in  1  PTE data valid
mem_rsp_data  in  PTE_WIDTH  PTE
mem_rsp_ready  out  1  walker accepts PTE
perf_walks  out  `PERF_CTR_BITS  completed walks
perf_faults  out  `PERF_CTR_BITS  faulted walks

Behaviour:
- Reset: state IDLE; all valid/ready outputs 0 except tlb_miss_ready_o as given by IDLE rule; perf counters 0; arbiter pointer at bank 0. Reset mid-walk abandons the walk, no update issued; the memory side is reset together with the walker, so no stale responses arrive.
- States: IDLE, MEM_REQ, MEM_RSP, RESP.
- IDLE: round-robin grant among asserted tlb_miss_valid_i; tlb_miss_ready_o = grant (0 in all other states). On valid&ready: latch bank id, VPN, base = satp_ppn, level = LEVELS-1, advance pointer past winner -> MEM_REQ.
- MEM_REQ: mem_req_valid=1, addr = {base, PAGE_OFFSET_WIDTH'0} + idx[level]*PTE_BYTES, computed at `XLEN width, overflow wraps. Addr stable until mem_req_ready -> MEM_RSP.
- MEM_RSP: mem_rsp_ready=1. On mem_rsp_valid, decode PTE: V=bit0, R/W/X=bits1..3, PPN=pte[PTE_WIDTH-1:10], zero-extended/truncated to PPN_WIDTH.
  - V=0 -> fault, RESP.
  - leaf (any R/W/X) at level 0 -> ppn=PTE PPN, RESP.
  - leaf at level>0 (superpage, unsupported) -> fault, RESP.
  - non-leaf at level 0 -> fault, RESP.
  - non-leaf at level>0 -> base=PTE PPN, level-1, MEM_REQ.
- RESP: tlb_update_valid_o[bank]=1 only for the latched bank; data held until tlb_update_ready_i[bank]; then perf_walks+1 (perf_faults+1 if fault) -> IDLE. A new miss can be granted in the cycle after the handshake, not in the same cycle.
- Latency with zero-wait memory (ready=1, rsp one cycle after req): accept T, req T+1, rsp T+2, per extra level +2, update valid T+1+2*LEVELS.
- Miss valid must stay high until granted; a bank whose miss was accepted gets no further grant until its update completes (single walk guarantees this).

Decomposition:
- Shared package VX_gpu_pkg: PTE bit positions (PTE_V, PTE_R, PTE_W, PTE_X, PTE_PPN_LSB=10), ptw state enum, ptw_perf_t (walks, faults).
- Sub-module: existing VX_generic_arbiter (round-robin, "R") for miss arbitration; walk FSM inline.

Test Plan:
- XLEN=32, satp_ppn=0x00080, bank 2 miss VPN=0x12345; mem@0x80120 returns 0x00024001, mem@0x90D14 returns 0x2AF37807 -> update_valid_o=4'b0100, ppn=0xABCDE, fault=0, vpn=0x12345, latency 5 cycles.
- Same, first PTE=0x00024000 (V=0) -> one mem request only, update fault=1, ppn=0, perf_faults=1.
- First PTE=0x00024003 (leaf at level 1) -> fault=1 after one read; second PTE non-leaf 0x00024001 -> fault=1 after two reads.
- Banks 0,1,3 miss simultaneously, continuous -> grants in order 0,1,3, then 0; one walk at a time; mem_req_valid never asserted while RESP.
- mem_req_ready held 0 for 5 cycles, tlb_update_ready_i held 0 for 3 cycles -> mem_req_addr and update outputs stable, no duplicate requests, perf_walks increments once.
- Reset asserted during MEM_RSP -> next cycle all outputs idle, no update issued, new miss walks correctly afterward.
